gru_gate_mac: RTL and testbench

- Upstream feeder of the GRU cell: streams one input vector x and one hidden vector h with per-gate weight rows.
- Accumulates the six gate pre-activations in Q8.24: ir, iz, in over x; hr, hz, hn over h.
- Holds the results stable on output ports that drive the GRU cell's data_ir/iz/in/hr/hz/hn inputs.
- Handshaked streaming input; valid/ready result output.

---
 rtl/gru_pkg.sv | 9 +
 rtl/gru_mac_lane.sv | 45 ++++
 rtl/gru_gate_mac.sv | 105 ++++++++++
 tb/tb_gru_gate_mac.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/gru_pkg.sv
// gru_pkg: shared widths, Q8.24 constants and FSM state encoding for gru_gate_mac
package gru_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int QUAN = 24;
    localparam logic [DATA_WIDTH-1:0] ONE_Q = 32'h0100_0000;
    localparam logic [DATA_WIDTH-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = 32'h8000_0000;
    typedef enum logic [2:0] {IDLE, BIAS_X, ACC_X, BIAS_H, ACC_H, DRAIN, OUT} state_t;
endpackage

// File: rtl/gru_mac_lane.sv
// gru_mac_lane: one gate lane (multiply, truncate, bias load, accumulate, hold); GRU_GATE_MAC_ACC_SAT_EN selects saturation
module gru_mac_lane import gru_pkg::*; #(
    parameter int DW = DATA_WIDTH,
    parameter int Q = QUAN
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          bias_ld,
    input  logic          mul_en,
    input  logic          add_en,
    input  logic          out_ld,
    input  logic [DW-1:0] data,
    input  logic [DW-1:0] w,
`ifdef GRU_GATE_MAC_ACC_SAT_EN
    output logic          sat,
`endif
    output logic [DW-1:0] q
);
    logic [2*DW-1:0] p;
    logic [DW-1:0] prod, acc, sum, acc_nxt;
    assign p = {{DW{data[DW-1]}}, data} * {{DW{w[DW-1]}}, w};
`ifdef GRU_GATE_MAC_ACC_SAT_EN
    logic [DW:0] s;
    logic ovf;
    assign s = {acc[DW-1], acc} + {prod[DW-1], prod};
    assign ovf = s[DW] != s[DW-1];
    assign sum = ovf ? (s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}}) : s[DW-1:0];
    assign sat = add_en && ovf;
`else
    assign sum = acc + prod;
`endif
    assign acc_nxt = bias_ld ? w : add_en ? sum : acc;
    // output register takes acc_nxt so the final product is included on OUT entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod <= '0;
            acc <= '0;
            q <= '0;
        end else begin
            if (mul_en) prod <= DW'(p >> Q);
            acc <= acc_nxt;
            if (out_ld) q <= acc_nxt;
        end
    end
endmodule

// File: rtl/gru_gate_mac.sv
// gru_gate_mac: streams x/h beats into six gate MAC lanes; GRU_GATE_MAC_ACC_SAT_EN adds saturation and sat_flag
module gru_gate_mac import gru_pkg::*; #(
    parameter int DATA_WIDTH = gru_pkg::DATA_WIDTH,
    parameter int QUAN = gru_pkg::QUAN,
    parameter int IN_LEN = 16,
    parameter int HID_LEN = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [DATA_WIDTH-1:0] in_w_r,
    input  logic [DATA_WIDTH-1:0] in_w_z,
    input  logic [DATA_WIDTH-1:0] in_w_n,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef GRU_GATE_MAC_ACC_SAT_EN
    output logic                  sat_flag,
`endif
    output logic [DATA_WIDTH-1:0] data_ir,
    output logic [DATA_WIDTH-1:0] data_iz,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_hr,
    output logic [DATA_WIDTH-1:0] data_hz,
    output logic [DATA_WIDTH-1:0] data_hn
);
    localparam int CW = $clog2((IN_LEN > HID_LEN ? IN_LEN : HID_LEN) + 1);
    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic fire, x_bias, x_mul, h_bias, h_mul, x_pv, h_pv, out_ld;
    logic [2:0][DATA_WIDTH-1:0] wt;
    logic [5:0][DATA_WIDTH-1:0] q;
    assign fire = in_valid && in_ready;
    assign wt = {in_w_n, in_w_z, in_w_r};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= nxt;
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? BIAS_X : IDLE;
            BIAS_X:  nxt = fire ? ACC_X : BIAS_X;
            ACC_X:   nxt = fire && cnt == CW'(IN_LEN - 1) ? BIAS_H : ACC_X;
            BIAS_H:  nxt = fire ? ACC_H : BIAS_H;
            ACC_H:   nxt = fire && cnt == CW'(HID_LEN - 1) ? DRAIN : ACC_H;
            DRAIN:   nxt = OUT;
            OUT:     nxt = out_ready ? IDLE : OUT;
            default: nxt = IDLE;
        endcase
    end
    always_comb begin
        in_ready = state inside {BIAS_X, ACC_X, BIAS_H, ACC_H};
        out_valid = state == OUT;
        x_bias = fire && state == BIAS_X;
        x_mul = fire && state == ACC_X;
        h_bias = fire && state == BIAS_H;
        h_mul = fire && state == ACC_H;
        out_ld = state == DRAIN;
    end
    // product-valid flags delay each group's add by one edge behind its multiply
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            x_pv <= 1'b0;
            h_pv <= 1'b0;
        end else begin
            cnt <= (x_bias || h_bias) ? '0 : (x_mul || h_mul) ? cnt + CW'(1) : cnt;
            x_pv <= x_mul;
            h_pv <= h_mul;
        end
    end
`ifdef GRU_GATE_MAC_ACC_SAT_EN
    logic [5:0] sat;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sat_flag <= 1'b0;
        else if (state == IDLE && start) sat_flag <= 1'b0;
        else if (|sat) sat_flag <= 1'b1;
    end
`endif
    for (genvar g = 0; g < 6; g++) begin : g_lane
        gru_mac_lane #(.DW(DATA_WIDTH), .Q(QUAN)) u_lane (
            .clk(clk),
            .rst_n(rst_n),
            .bias_ld(g < 3 ? x_bias : h_bias),
            .mul_en(g < 3 ? x_mul : h_mul),
            .add_en(g < 3 ? x_pv : h_pv),
            .out_ld(out_ld),
            .data(in_data),
            .w(wt[g % 3]),
`ifdef GRU_GATE_MAC_ACC_SAT_EN
            .sat(sat[g]),
`endif
            .q(q[g])
        );
    end
    assign data_ir = q[0];
    assign data_iz = q[1];
    assign data_in = q[2];
    assign data_hr = q[3];
    assign data_hz = q[4];
    assign data_hn = q[5];
endmodule

// File: tb/tb_gru_gate_mac.sv
// tb_gru_gate_mac: randomized scoreboard bench for gru_gate_mac against a plain-arithmetic gate model
module tb_gru_gate_mac;
    localparam int IL = 2;
    localparam int HL = 2;
    logic clk = 0, rst_n = 0, start = 0, in_valid = 0, out_ready = 0;
    logic [31:0] in_data = 0, in_w_r = 0, in_w_z = 0, in_w_n = 0;
    logic in_ready, out_valid;
    logic [31:0] d_ir, d_iz, d_in, d_hr, d_hz, d_hn;
`ifdef GRU_GATE_MAC_ACC_SAT_EN
    logic sat_flag;
`endif
    gru_gate_mac #(.IN_LEN(IL), .HID_LEN(HL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_w_r(in_w_r), .in_w_z(in_w_z), .in_w_n(in_w_n),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef GRU_GATE_MAC_ACC_SAT_EN
        .sat_flag(sat_flag),
`endif
        .data_ir(d_ir), .data_iz(d_iz), .data_in(d_in),
        .data_hr(d_hr), .data_hz(d_hz), .data_hn(d_hn)
    );
    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0][31:0] v;
        logic sat;
    } exp_t;
    exp_t sb[$];
    exp_t last;
    int vectors = 0, errs = 0;
    logic [31:0] xs[IL], hs[HL], wx[3][IL], wh[3][HL], bx[3], bh[3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    // gate value from the arithmetic rules: bias + sum of truncated Q8.24 products
    function automatic logic [31:0] gate(input logic [31:0] b, input int g, input bit is_h, output bit s);
        longint acc = longint'($signed(b));
        int n = is_h ? HL : IL;
        s = 0;
        for (int i = 0; i < n; i++) begin
            longint p = longint'($signed(is_h ? hs[i] : xs[i])) * longint'($signed(is_h ? wh[g][i] : wx[g][i]));
            acc += longint'(int'(p >>> 24));
`ifdef GRU_GATE_MAC_ACC_SAT_EN
            if (acc > 64'sd2147483647) begin acc = 64'sd2147483647; s = 1; end
            else if (acc < -64'sd2147483648) begin acc = -64'sd2147483648; s = 1; end
`else
            acc = longint'(int'(acc));
`endif
        end
        return 32'(acc);
    endfunction

    task automatic setv(input logic [31:0] b, x0, x1, wxa, h0, h1, wha);
        for (int g = 0; g < 3; g++) begin
            bx[g] = b; bh[g] = b;
            wx[g][0] = wxa; wx[g][1] = wxa; wh[g][0] = wha; wh[g][1] = wha;
        end
        xs[0] = x0; xs[1] = x1; hs[0] = h0; hs[1] = h1;
    endtask

    task automatic beat(input logic [31:0] d, r, z, n, input bit gaps);
        int t = 0;
        bit ok = 0;
        if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        in_valid = 1; in_data = d; in_w_r = r; in_w_z = z; in_w_n = n;
        while (!ok && t < 20) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            t++;
        end
        in_valid = 0; in_data = $urandom; in_w_r = $urandom; in_w_z = $urandom; in_w_n = $urandom;
        if (!ok) chk("beat_timeout", 0, 1);
    endtask

    task automatic run(input bit gaps, input int bp, input int abort_at);
        exp_t e;
        bit s;
        logic [31:0] bd[2+IL+HL], br[2+IL+HL], bz[2+IL+HL], bn[2+IL+HL];
        e = '0;
        for (int g = 0; g < 3; g++) begin
            e.v[g] = gate(bx[g], g, 0, s); e.sat |= s;
            e.v[g+3] = gate(bh[g], g, 1, s); e.sat |= s;
        end
        bd[0] = $urandom; br[0] = bx[0]; bz[0] = bx[1]; bn[0] = bx[2];
        for (int i = 0; i < IL; i++) begin
            bd[1+i] = xs[i]; br[1+i] = wx[0][i]; bz[1+i] = wx[1][i]; bn[1+i] = wx[2][i];
        end
        bd[1+IL] = $urandom; br[1+IL] = bh[0]; bz[1+IL] = bh[1]; bn[1+IL] = bh[2];
        for (int i = 0; i < HL; i++) begin
            bd[2+IL+i] = hs[i]; br[2+IL+i] = wh[0][i]; bz[2+IL+i] = wh[1][i]; bn[2+IL+i] = wh[2][i];
        end
        start = 1; @(posedge clk); #1; start = 0;
        for (int k = 0; k < 2 + IL + HL; k++) begin
            if (k == abort_at) begin
                chk("pre_abort_ready", {31'b0, in_ready}, 1);
                #2 rst_n = 0;
                #1;
                chk("abort_ready", {31'b0, in_ready}, 0);
                chk("abort_valid", {31'b0, out_valid}, 0);
                chk("abort_ir", d_ir, 0);
                chk("abort_hn", d_hn, 0);
                @(negedge clk); rst_n = 1;
                @(posedge clk); #1;
                return;
            end
            beat(bd[k], br[k], bz[k], bn[k], gaps);
        end
        sb.push_back(e);
        last = e;
        chk("drain_ready", {31'b0, in_ready}, 0);
        chk("drain_valid", {31'b0, out_valid}, 0);
        @(posedge clk); #1;
        chk("latency_valid", {31'b0, out_valid}, 1);
        chk("out_ready_low", {31'b0, in_ready}, 0);
        repeat (bp) begin
            start = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            start = 0;
            chk("bp_valid", {31'b0, out_valid}, 1);
        end
        out_ready = 1; start = 1;
        @(posedge clk); #1;
        out_ready = 0; start = 0;
        chk("idle_valid", {31'b0, out_valid}, 0);
        @(posedge clk); #1;
        chk("start_dropped", {31'b0, in_ready}, 0);
        chk("hold_ir", d_ir, e.v[0]);
        chk("hold_hn", d_hn, e.v[5]);
    endtask

    initial begin : monitor
        logic [5:0][31:0] act;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (sb.size() == 0) chk("unexpected_out", 1, 0);
                else begin
                    act = {d_hn, d_hz, d_hr, d_in, d_iz, d_ir};
                    for (int g = 0; g < 6; g++) chk($sformatf("data_%0d", g), act[g], sb[0].v[g]);
`ifdef GRU_GATE_MAC_ACC_SAT_EN
                    chk("sat_flag", {31'b0, sat_flag}, {31'b0, sb[0].sat});
`endif
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #2;
        chk("rst_ready", {31'b0, in_ready}, 0);
        chk("rst_valid", {31'b0, out_valid}, 0);
        chk("rst_ir", d_ir, 0); chk("rst_iz", d_iz, 0); chk("rst_in", d_in, 0);
        chk("rst_hr", d_hr, 0); chk("rst_hz", d_hz, 0); chk("rst_hn", d_hn, 0);
        #10 rst_n = 1;
        @(posedge clk); #1;
        setv(32'h0080_0000, 32'h0100_0000, 32'h0200_0000, 32'h0040_0000, 32'h0100_0000, 32'h0100_0000, 32'h0080_0000);
        run(0, 10, -1);
        run(1, 0, -1);
        setv(0, 32'hFF00_0000, 0, 32'h0080_0000, 0, 0, 0);
        run(0, 1, -1);
        setv(0, 0, 0, 0, 32'h7F00_0000, 32'h7F00_0000, 32'h0100_0000);
        run(0, 0, -1);
        setv(32'h0080_0000, 32'h0100_0000, 32'h0200_0000, 32'h0040_0000, 32'h0100_0000, 32'h0100_0000, 32'h0080_0000);
        run(0, 0, 2);
        run(0, 2, -1);
        repeat (20) begin
            for (int g = 0; g < 3; g++) begin
                bx[g] = $urandom; bh[g] = $urandom;
                for (int i = 0; i < IL; i++) wx[g][i] = $urandom;
                for (int i = 0; i < HL; i++) wh[g][i] = $urandom;
            end
            for (int i = 0; i < IL; i++) xs[i] = $urandom;
            for (int i = 0; i < HL; i++) hs[i] = $urandom;
            run(1'($urandom_range(0, 1)), $urandom_range(0, 3), -1);
        end
        repeat (3) @(posedge clk);
        #1 chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
